// File: rtl/golden_nonce_uart_tx_if.sv
// Signal bundle between the hash core (master) and the golden-nonce UART transmitter (slave).
// The master drives the nonce/strobe pair; the slave drives the serial line and status.
interface golden_nonce_uart_tx_if #(
  parameter int FIFO_AW = 2
);
  logic [31:0]      golden_nonce;
  logic             golden_nonce_match;
  logic             txd;
  logic             busy;
  logic [FIFO_AW:0] fifo_level;
  logic [7:0]       overflow_count;

  modport master (
    output golden_nonce,
    output golden_nonce_match,
    input  txd,
    input  busy,
    input  fifo_level,
    input  overflow_count
  );

  modport slave (
    input  golden_nonce,
    input  golden_nonce_match,
    output txd,
    output busy,
    output fifo_level,
    output overflow_count
  );
endinterface

// File: rtl/golden_nonce_uart_tx.sv
// FIFO-buffered 8N1 UART serialiser sending each golden nonce as a little-endian frame.
// Define NONCE_FRAME_CHECKSUM_EN to append an XOR checksum byte after nonce[31:24].
module golden_nonce_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 2
) (
  input  logic                  hash_clk,
  input  logic                  reset_n,
  golden_nonce_uart_tx_if.slave bus
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(CLKS_PER_BIT);
`ifdef NONCE_FRAME_CHECKSUM_EN
  localparam int SW     = 40;
  localparam int NBYTES = 5;
`else
  localparam int SW     = 32;
  localparam int NBYTES = 4;
`endif

  localparam logic [CW-1:0]      CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]      CNT_ONE   = CW'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   LVL_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   LVL_FULL  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [2:0]         LAST_BYTE = 3'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_clk_cnt;
  logic [CW-1:0]    w_clk_cnt_nxt;
  logic [2:0]       r_bit_cnt;
  logic [2:0]       w_bit_cnt_nxt;
  logic [2:0]       r_byte_cnt;
  logic [2:0]       w_byte_cnt_nxt;
  logic [SW-1:0]    r_shift;
  logic [SW-1:0]    w_shift_nxt;
  logic             r_txd;
  logic             w_txd_nxt;
  logic             r_busy;

  logic [31:0]      r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0] r_level;
  logic [FIFO_AW:0] w_level_nxt;
  logic [7:0]       r_ovf;

  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_full;
  logic             w_bit_done;
  logic [31:0]      w_head;
  logic [SW-1:0]    w_load_word;

  assign w_full     = (r_level == LVL_FULL);
  assign w_push     = bus.golden_nonce_match & (~w_full | w_pop);
  assign w_drop     = bus.golden_nonce_match & ~w_push;
  assign w_bit_done = (r_clk_cnt == CNT_MAX);
  assign w_head     = r_mem[r_rptr];

`ifdef NONCE_FRAME_CHECKSUM_EN
  assign w_load_word = {w_head[31:24] ^ w_head[23:16] ^ w_head[15:8] ^ w_head[7:0], w_head};
`else
  assign w_load_word = w_head;
`endif

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LVL_ONE;
      2'b01:   w_level_nxt = r_level - LVL_ONE;
      default: w_level_nxt = r_level;
    endcase
  end

  // The shift word moves right once per data bit, so after eight bits the next byte sits in [7:0].
  always_comb begin
    w_state_nxt    = r_state;
    w_clk_cnt_nxt  = r_clk_cnt;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_byte_cnt_nxt = r_byte_cnt;
    w_shift_nxt    = r_shift;
    w_txd_nxt      = r_txd;
    w_pop          = 1'b0;
    case (r_state)
      IDLE: begin
        w_txd_nxt = 1'b1;
        if (r_level != '0) begin
          w_pop          = 1'b1;
          w_state_nxt    = START;
          w_shift_nxt    = w_load_word;
          w_clk_cnt_nxt  = '0;
          w_byte_cnt_nxt = '0;
          w_txd_nxt      = 1'b0;
        end
      end
      START: begin
        w_clk_cnt_nxt = w_bit_done ? '0 : r_clk_cnt + CNT_ONE;
        if (w_bit_done) begin
          w_state_nxt   = DATA;
          w_bit_cnt_nxt = '0;
          w_txd_nxt     = r_shift[0];
        end
      end
      DATA: begin
        w_clk_cnt_nxt = w_bit_done ? '0 : r_clk_cnt + CNT_ONE;
        if (w_bit_done) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = STOP;
            w_txd_nxt   = 1'b1;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            w_txd_nxt     = r_shift[1];
          end
        end
      end
      STOP: begin
        w_clk_cnt_nxt = w_bit_done ? '0 : r_clk_cnt + CNT_ONE;
        if (w_bit_done) begin
          if (r_byte_cnt == LAST_BYTE) begin
            w_state_nxt = IDLE;
            w_txd_nxt   = 1'b1;
          end else begin
            w_state_nxt    = START;
            w_byte_cnt_nxt = r_byte_cnt + 3'd1;
            w_txd_nxt      = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge hash_clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_clk_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clk_cnt  <= w_clk_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_txd      <= w_txd_nxt;
      r_busy     <= (w_state_nxt != IDLE) | (w_level_nxt != '0);
    end
  end

  // A full FIFO still accepts a write when the head is popped on the same edge.
  always_ff @(posedge hash_clk) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      r_level <= w_level_nxt;
      if (w_drop && (r_ovf != 8'hFF)) r_ovf <= r_ovf + 8'd1;
    end
  end

  always_ff @(posedge hash_clk) begin
    if (w_push) r_mem[r_wptr] <= bus.golden_nonce;
  end

  assign bus.txd            = r_txd;
  assign bus.busy           = r_busy;
  assign bus.fifo_level     = r_level;
  assign bus.overflow_count = r_ovf;

endmodule

// File: tb/tb_golden_nonce_uart_tx.sv
// Scoreboard bench for golden_nonce_uart_tx: expected bytes are queued at stimulus time
// and a UART receiver process decodes txd and compares each received byte.
module tb_golden_nonce_uart_tx;
  localparam int CPB = 4;
  localparam int AW  = 2;
`ifdef NONCE_FRAME_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int FRAME = NB * 10 * CPB;

  logic hash_clk = 1'b0;
  logic reset_n  = 1'b0;
  int   cycle    = 0;
  int   total    = 0;
  int   bad      = 0;
  bit   monEnable = 1'b0;
  logic [7:0] expQ[$];
  int   startTimes[$];

  golden_nonce_uart_tx_if #(.FIFO_AW(AW)) bus();

  golden_nonce_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .hash_clk(hash_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 hash_clk = ~hash_clk;
  always @(posedge hash_clk) cycle <= cycle + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic expectNonce(input logic [31:0] n);
    for (int k = 0; k < 4; k++) expQ.push_back(n[8*k +: 8]);
`ifdef NONCE_FRAME_CHECKSUM_EN
    expQ.push_back(n[7:0] ^ n[15:8] ^ n[23:16] ^ n[31:24]);
`endif
  endtask

  task automatic applyStimulus(input logic [31:0] n);
    bus.golden_nonce       = n;
    bus.golden_nonce_match = 1'b1;
    @(posedge hash_clk); #1;
    bus.golden_nonce_match = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < budget) begin
      @(posedge hash_clk); #1;
      n++;
    end
    checkOutput(name, {31'd0, bus.busy}, 32'd0);
  endtask

  // Receiver samples each bit in its middle, starting from the edge where txd first reads low.
  initial begin : monitor
    logic [7:0] rx;
    logic [7:0] want;
    forever begin
      @(posedge hash_clk); #1;
      if (monEnable && bus.txd === 1'b0) begin
        startTimes.push_back(cycle);
        repeat (CPB / 2) @(posedge hash_clk);
        #1;
        checkOutput("startBit", {31'd0, bus.txd}, 32'd0);
        for (int b = 0; b < 8; b++) begin
          repeat (CPB) @(posedge hash_clk);
          #1;
          rx[b] = bus.txd;
        end
        repeat (CPB) @(posedge hash_clk);
        #1;
        checkOutput("stopBit", {31'd0, bus.txd}, 32'd1);
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL rxByte: got 0x%0h want no byte", rx);
        end else begin
          want = expQ.pop_front();
          checkOutput("rxByte", {24'd0, rx}, {24'd0, want});
        end
      end
    end
  end

  initial begin : stimulus
    int e0;
    int tgt;
    int quiet;
    int diff;
    bus.golden_nonce       = 32'd0;
    bus.golden_nonce_match = 1'b0;

    reset_n = 1'b0;
    repeat (3) @(posedge hash_clk);
    #1;
    reset_n = 1'b1;
    repeat (100) @(posedge hash_clk);
    #1;
    checkOutput("resetTxd", {31'd0, bus.txd}, 32'd1);
    checkOutput("resetBusy", {31'd0, bus.busy}, 32'd0);
    checkOutput("resetLevel", {29'd0, bus.fifo_level}, 32'd0);
    checkOutput("resetOverflow", {24'd0, bus.overflow_count}, 32'd0);

    monEnable = 1'b1;
    expectNonce(32'h12345678);
    applyStimulus(32'h12345678);
    checkOutput("singleLevelAfterWrite", {29'd0, bus.fifo_level}, 32'd1);
    checkOutput("singleTxdBeforePop", {31'd0, bus.txd}, 32'd1);
    @(posedge hash_clk); #1;
    checkOutput("singleStartBit", {31'd0, bus.txd}, 32'd0);
    checkOutput("singleLevelAfterPop", {29'd0, bus.fifo_level}, 32'd0);
    repeat (FRAME - 1) @(posedge hash_clk);
    #1;
    checkOutput("singleBusyInStop", {31'd0, bus.busy}, 32'd1);
    @(posedge hash_clk); #1;
    checkOutput("singleBusyAfterFrame", {31'd0, bus.busy}, 32'd0);
    checkOutput("singleTxdAfterFrame", {31'd0, bus.txd}, 32'd1);
    repeat (5) @(posedge hash_clk);
    #1;
    checkOutput("singleBytesLeft", expQ.size(), 32'd0);

    startTimes.delete();
    e0 = 0;
    for (int i = 1; i <= 6; i++) begin
      if (i != 6) expectNonce(32'(i));
      applyStimulus(32'(i));
      if (i == 1) e0 = cycle;
    end
    checkOutput("burstLevel", {29'd0, bus.fifo_level}, 32'd4);
    checkOutput("burstOverflow", {24'd0, bus.overflow_count}, 32'd1);

    tgt = e0 + FRAME + 2;
    while (cycle < tgt - 1) begin
      @(posedge hash_clk); #1;
    end
    checkOutput("fullBeforeCoPop", {29'd0, bus.fifo_level}, 32'd4);
    expectNonce(32'h7);
    applyStimulus(32'h7);
    checkOutput("coPopLevel", {29'd0, bus.fifo_level}, 32'd4);
    checkOutput("coPopOverflow", {24'd0, bus.overflow_count}, 32'd1);

    waitIdle("burstDrain", 3000);
    repeat (4) @(posedge hash_clk);
    #1;
    checkOutput("burstBytesLeft", expQ.size(), 32'd0);
    checkOutput("burstStartCount", startTimes.size(), 32'(6 * NB));
    if (startTimes.size() > 0) checkOutput("burstFirstStart", startTimes[0], e0 + 1);
    for (int i = 1; i < startTimes.size(); i++) begin
      diff = startTimes[i] - startTimes[i-1];
      checkOutput("byteSpacing", diff, (i % NB == 0) ? 10 * CPB + 1 : 10 * CPB);
    end

    monEnable = 1'b0;
    for (int i = 0; i < 300; i++) applyStimulus(32'hC0DE0000 + 32'(i));
    checkOutput("overflowSaturated", {24'd0, bus.overflow_count}, 32'd255);

    reset_n = 1'b0;
    @(posedge hash_clk); #1;
    checkOutput("reset2Overflow", {24'd0, bus.overflow_count}, 32'd0);
    checkOutput("reset2Level", {29'd0, bus.fifo_level}, 32'd0);
    checkOutput("reset2Txd", {31'd0, bus.txd}, 32'd1);
    reset_n = 1'b1;
    repeat (3) @(posedge hash_clk);
    #1;

    // Byte 2 is 0xB2; its data bit 2 (a zero) is on the line 94 cycles after the pop.
    applyStimulus(32'hA1B2C3D4);
    e0 = cycle;
    applyStimulus(32'h55AA55AA);
    tgt = e0 + 95;
    while (cycle < tgt) begin
      @(posedge hash_clk); #1;
    end
    checkOutput("abortPreTxd", {31'd0, bus.txd}, 32'd0);
    checkOutput("abortPreLevel", {29'd0, bus.fifo_level}, 32'd1);
    reset_n = 1'b0;
    @(posedge hash_clk); #1;
    checkOutput("abortTxd", {31'd0, bus.txd}, 32'd1);
    checkOutput("abortLevel", {29'd0, bus.fifo_level}, 32'd0);
    checkOutput("abortBusy", {31'd0, bus.busy}, 32'd0);
    reset_n = 1'b1;
    quiet = 0;
    repeat (100) begin
      @(posedge hash_clk); #1;
      if (bus.txd !== 1'b1 || bus.busy !== 1'b0) quiet++;
    end
    checkOutput("abortLineQuiet", quiet, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/golden_nonce_uart_tx.md
# golden_nonce_uart_tx

Downstream consumer of the hash core's match output: queues every `golden_nonce` captured on a `golden_nonce_match` strobe and serialises each one onto an 8N1 UART line as a fixed little-endian frame for the host. The block runs entirely in the hash clock domain and sits between the hash core and the board's serial TX pin. A small FIFO absorbs bursts of matches that arrive faster than the line can drain them.

## Interface
- `CLKS_PER_BIT`, 434 — `hash_clk` cycles per UART bit (≥2).
- `FIFO_AW`, 2 — FIFO address width; depth = 2^FIFO_AW entries of 32 bits.
- `hash_clk`  in  1  sole clock, all logic on rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `golden_nonce`  in  32  nonce from hash core, valid when strobe high.
- `golden_nonce_match`  in  1  one-cycle strobe; each high cycle is one independent match.
- `txd`  out  1  UART serial data, idle high.
- `busy`  out  1  high while a frame is being transmitted or FIFO non-empty.
- `fifo_level`  out  FIFO_AW+1  entries currently queued (0..2^FIFO_AW).
- `overflow_count`  out  8  matches dropped due to full FIFO, saturates at 255.

## Operation
- Reset (`reset_n` low at an edge): `txd`=1, `busy`=0, `fifo_level`=0, `overflow_count`=0, FSM→IDLE, FIFO pointers cleared; in-flight frame aborted, line returns high on the next edge.
- Write: strobe high at edge E → `golden_nonce` stored at E if FIFO not full, or if full and a pop happens at the same edge; otherwise dropped and `overflow_count` increments (saturating).
- Pop: FSM in IDLE with FIFO non-empty pops head into 32-bit shift word and enters START.
- FSM states: IDLE → START (txd=0) → DATA (8 bits, LSB first) → STOP (txd=1) → next byte's START, or IDLE after last byte.
- Byte order: `nonce[7:0]`, `[15:8]`, `[23:16]`, `[31:24]`.
- Each START/DATA/STOP bit held exactly CLKS_PER_BIT cycles; bit counter and byte counter wrap cleanly, no gap between bytes.
- `fifo_level` = writes − pops, updated at the same edge; simultaneous write+pop leaves level unchanged.
- `busy` = (FSM≠IDLE) | (fifo_level≠0), registered.

## Timing
- Strobe high in cycle before edge E0 → entry written at E0 → FSM pops at E1 → `txd` low from E1 (start bit) if FSM was idle.
- Frame = 4 bytes × 10 bits × CLKS_PER_BIT cycles (40·CLKS_PER_BIT).
- After final stop bit FSM spends exactly one cycle in IDLE before popping the next queued entry.
- Matches on consecutive cycles each occupy one FIFO entry; order preserved.
- Reset mid-frame: partial frame not resumed; queued entries discarded.

## Configuration
- `NONCE_FRAME_CHECKSUM_EN` defined: a fifth byte, XOR of the four nonce bytes, is sent after `nonce[31:24]`; frame = 50·CLKS_PER_BIT cycles.
- Undefined: 4-byte frame only, no checksum logic instantiated.

## Test plan
- Reset then idle 100 cycles → `txd`=1, `busy`=0, `fifo_level`=0, `overflow_count`=0.
- CLKS_PER_BIT=4, single strobe with nonce 0x12345678 → start bit one cycle after write; bytes 0x78,0x56,0x34,0x12 decoded LSB-first; frame ends after 160 cycles (200 with checksum, 5th byte 0x08); `busy` falls after.
- FIFO_AW=2, six strobes on consecutive cycles (0x1..0x6) while idle → first pops immediately, next four queued, sixth dropped; `overflow_count`=1; host receives 0x1..0x5 in order with one idle cycle between frames.
- Strobe coincident with pop while FIFO full → entry accepted, `overflow_count` unchanged, `fifo_level` stays 4.
- 300 strobes with FIFO held full → `overflow_count` saturates at 255.
- `reset_n` low during DATA of byte 2 → next edge `txd`=1, `fifo_level`=0; no further frame bits emitted.
